// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: widths, reset defaults, fetch FSM states and opcode constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem req/rsp handshake and a 1-entry IF/ID register
// with decode back-pressure and branch/jump redirect.
module instr_fetch_stage #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7
);
  import riscv_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            slot_free_c;
  logic            req_fire_c;

  // A request may only go out when its response is guaranteed a free IF/ID slot.
  assign slot_free_c = !id_valid || id_ready;

  always_comb begin
    imem_req_valid = 1'b0;
    if (!rst && !redirect_valid && (state == S_REQ) && slot_free_c) begin
      imem_req_valid = 1'b1;
    end
  end

  assign req_fire_c    = imem_req_valid && imem_req_ready;
  assign imem_req_addr = pc;

  assign id_opcode = id_instr[6:0];
  assign id_funct3 = id_instr[14:12];
  assign id_funct7 = id_instr[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_pc   <= '0;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (redirect_valid) begin
      // Flush IF/ID; an outstanding response becomes stale unless it lands this very cycle.
      pc       <= redirect_target & ~XLEN'(3);
      id_valid <= 1'b0;
      if (state != S_REQ) begin
        state <= imem_rsp_valid ? S_REQ : S_DROP;
      end
    end else begin
      if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (req_fire_c) begin
            state  <= S_WAIT;
            req_pc <= pc;
            pc     <= pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            id_instr <= imem_rsp_data;
            id_pc    <= req_pc;
            id_valid <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
